// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: buffers command/data bytes in a small FIFO and replays each
// onto an HD44780-style LCD bus with setup, enable-pulse, hold and execution
// wait timing driven by one shared down-counter.
// Optional feature macro: LCD_LONG_CMD_WAIT_EN (long wait after clear/home).
// Handshake: a byte is taken at a rising edge when in_valid && in_ready;
// in_ready is registered state (!full) and never depends on in_valid.
`timescale 1ns/1ps
module lcd_bus_driver #(
  parameter int FIFO_AW          = 2,
  parameter int SETUP_CYCLES     = 2,
  parameter int PULSE_CYCLES     = 4,
  parameter int HOLD_CYCLES      = 2,
  parameter int DATA_WAIT_CYCLES = 10,
  parameter int CMD_WAIT_CYCLES  = 10,
  parameter int LONG_WAIT_CYCLES = 200,
  parameter int CNT_W            = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_rs,
  input  logic [7:0]         in_data,
  output logic [7:0]         lcd_data,
  output logic [1:0]         lcd_ctrl,
  output logic               lcd_enable,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT   = (FIFO_AW + 1)'(DEPTH);
  // Counter reload values: a state lasting N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DATA_LOAD  = CNT_W'(DATA_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

  logic [8:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic               rs_q, rs_d;
  logic               en_q, en_d;
  logic               push, pop, long_cmd;
  logic [CNT_W-1:0]   wait_load;

  assign push = in_valid && (count_q != FULL_CNT);
  assign pop  = (state_q == ST_IDLE) && (count_q != '0);

`ifdef LCD_LONG_CMD_WAIT_EN
  assign long_cmd = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));
`else
  assign long_cmd = 1'b0;
`endif

  assign wait_load = long_cmd ? LONG_LOAD : (rs_q ? DATA_LOAD : CMD_LOAD);

  // Next-state logic for FIFO pointers/occupancy and the bus timing FSM.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    rs_d     = rs_q;
    en_d     = en_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    case (state_q)
      ST_IDLE: begin
        en_d = 1'b0;
        if (pop) begin
          data_d  = mem_q[rd_ptr_q][7:0];
          rs_d    = mem_q[rd_ptr_q][8];
          cnt_d   = SETUP_LOAD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LOAD;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = wait_load;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        en_d    = 1'b0;
      end
    endcase
  end

  // Control and bus registers; reset aborts any transfer and empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rs_q     <= rs_d;
      en_q     <= en_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= {in_rs, in_data};
  end

  assign in_ready   = (count_q != FULL_CNT);
  assign fifo_count = count_q;
  assign busy       = (state_q != ST_IDLE) || (count_q != '0);
  assign lcd_data   = data_q;
  assign lcd_ctrl   = {rs_q, 1'b0};
  assign lcd_enable = en_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Bench for lcd_bus_driver: directed pushes feed an expected-byte queue, and a
// negedge monitor pops it on every E rising edge, checking bus contents, pulse
// width and hold stability. The main sequence checks timing points directly.
`timescale 1ns/1ps
module tb_lcd_bus_driver;

  localparam int FIFO_AW = 2;
  localparam int PULSE_W = 4;
  localparam int CMD_GAP = 19;
`ifdef LCD_LONG_CMD_WAIT_EN
  localparam int LONG_GAP = 209;
`else
  localparam int LONG_GAP = 19;
`endif

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_rs;
  logic [7:0]       in_data;
  logic [7:0]       lcd_data;
  logic [1:0]       lcd_ctrl;
  logic             lcd_enable;
  logic             busy;
  logic [FIFO_AW:0] fifo_count;

  lcd_bus_driver #(.FIFO_AW(FIFO_AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs      (in_rs),
    .in_data    (in_data),
    .lcd_data   (lcd_data),
    .lcd_ctrl   (lcd_ctrl),
    .lcd_enable (lcd_enable),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [8:0] exp_q[$];
  int         rise_cyc[$];
  int         rise_count = 0;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic rs, input logic [7:0] d, input logic acc);
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    chk("in_ready_at_push", in_ready, acc);
    if (acc) exp_q.push_back({rs, d});
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      step(1);
      n++;
    end
    chk(name, (n < budget), 1'b1);
  endtask

  function automatic int rise_gap(input int i);
    if (rise_cyc.size() > i) return rise_cyc[i] - rise_cyc[i-1];
    return -1;
  endfunction

  // Monitor: one expected byte per E pulse
  logic       prev_e = 1'b0;
  logic       pulse_abort = 1'b0;
  int         pulse_len = 0;
  logic [9:0] bus_at_rise = '0;
  logic [8:0] exp_b;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) pulse_abort = 1'b1;
      if (lcd_enable && !prev_e) begin
        rise_count++;
        rise_cyc.push_back(cyc);
        pulse_len   = 1;
        pulse_abort = !rst_n;
        bus_at_rise = {lcd_ctrl, lcd_data};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got bus %0h expected no pulse at cyc %0d",
                   {lcd_ctrl, lcd_data}, cyc);
        end else begin
          exp_b = exp_q.pop_front();
          chk("pulse_bus", {lcd_ctrl, lcd_data}, {exp_b[8], 1'b0, exp_b[7:0]});
        end
      end else if (lcd_enable) begin
        pulse_len++;
      end else if (prev_e && !pulse_abort) begin
        chk("pulse_width", pulse_len, PULSE_W);
        chk("hold_bus", {lcd_ctrl, lcd_data}, bus_at_rise);
      end
      prev_e = lcd_enable;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Main sequence
  int c0;
  int rc;

  initial begin
    // Reset with in_valid asserted: nothing accepted
    rst_n = 1'b0; in_valid = 1'b1; in_rs = 1'b1; in_data = 8'hA5;
    step(3);
    chk("rst_enable", lcd_enable, 1'b0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_ctrl", lcd_ctrl, 2'b00);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1; in_valid = 1'b0;
    chk("ready_after_rst", in_ready, 1'b1);
    step(2);
    chk("count_after_rst", fifo_count, 3'd0);
    chk("no_pulse_after_rst", rise_count, 0);

    // Single data byte timing
    rise_cyc.delete();
    c0 = cyc;
    push(1'b1, 8'h41, 1'b1);
    chk("single_count_c1", fifo_count, 3'd1);
    chk("single_busy_c1", busy, 1'b1);
    step(1);
    chk("single_data_c2", lcd_data, 8'h41);
    chk("single_ctrl_c2", lcd_ctrl, 2'b10);
    chk("single_e_c2", lcd_enable, 1'b0);
    chk("single_count_c2", fifo_count, 3'd0);
    step(1);
    chk("single_e_c3", lcd_enable, 1'b0);
    step(1);
    chk("single_e_c4", lcd_enable, 1'b1);
    step(3);
    chk("single_e_c7", lcd_enable, 1'b1);
    step(1);
    chk("single_e_c8", lcd_enable, 1'b0);
    chk("single_data_c8", lcd_data, 8'h41);
    step(11);
    chk("single_busy_c19", busy, 1'b1);
    step(1);
    chk("single_busy_c20", busy, 1'b0);
    chk("single_rise_cyc", (rise_cyc.size() > 0) ? rise_cyc[0] - c0 : -1, 4);
    step(2);

    // FIFO full: six back-to-back pushes, the sixth rejected
    rise_cyc.delete();
    rc = rise_count;
    push(1'b1, 8'h30, 1'b1);
    push(1'b1, 8'h31, 1'b1);
    push(1'b0, 8'h0C, 1'b1);
    push(1'b1, 8'h32, 1'b1);
    push(1'b1, 8'h33, 1'b1);
    chk("full_count", fifo_count, 3'd4);
    push(1'b1, 8'h34, 1'b0);
    chk("full_count_after_reject", fifo_count, 3'd4);
    wait_drain(400, "full_drain");
    chk("full_pulses", rise_count - rc, 5);
    for (int i = 1; i < 5; i++) chk("full_gap", rise_gap(i), CMD_GAP);
    step(2);

    // Reset during the pulse of the second of three bytes
    rc = rise_count;
    push(1'b1, 8'h50, 1'b1);
    push(1'b1, 8'h51, 1'b1);
    push(1'b1, 8'h52, 1'b1);
    step(21);
    chk("midrst_e_before", lcd_enable, 1'b1);
    chk("midrst_pulses_before", rise_count - rc, 2);
    rst_n = 1'b0;
    exp_q.delete();
    step(1);
    chk("midrst_e", lcd_enable, 1'b0);
    chk("midrst_count", fifo_count, 3'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_data", lcd_data, 8'h00);
    rst_n = 1'b1;
    rc = rise_count;
    step(60);
    chk("midrst_no_pulses", rise_count - rc, 0);
    chk("midrst_idle", busy, 1'b0);

    // Command then data: pop-to-pop gap
    rise_cyc.delete();
    push(1'b0, 8'h38, 1'b1);
    push(1'b1, 8'h48, 1'b1);
    wait_drain(200, "cmd_drain");
    chk("cmd_gap", rise_gap(1), CMD_GAP);
    step(2);

    // Clear command then data: long wait when the feature is built in
    rise_cyc.delete();
    push(1'b0, 8'h01, 1'b1);
    push(1'b1, 8'h41, 1'b1);
    wait_drain(600, "long_drain");
    chk("long_gap", rise_gap(1), LONG_GAP);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_bus_driver.md
Name: lcd_bus_driver

Overview:
- Downstream stage between the CPU's memory-mapped LCD port and the physical HD44780-style character LCD.
- Accepts command/data bytes on a valid/ready interface and buffers them in a small FIFO.
- Replays each byte onto the LCD bus with programmed setup, enable-pulse, hold and execution-wait timing, so software no longer bit-bangs lcd_enable.

Parameters:
FIFO_AW, 2, log2 of FIFO depth; depth = 2**FIFO_AW entries
SETUP_CYCLES, 2, cycles data/RS stable with E low before E rises (>=1)
PULSE_CYCLES, 4, cycles E held high (>=1)
HOLD_CYCLES, 2, cycles data/RS held after E falls (>=1)
DATA_WAIT_CYCLES, 10, execution wait after an RS=1 (data) write (>=1)
CMD_WAIT_CYCLES, 10, execution wait after an RS=0 (command) write (>=1)
LONG_WAIT_CYCLES, 200, wait after clear/home commands; used only with the optional feature (>=1)
CNT_W, 16, width of the shared timing counter; every *_CYCLES parameter must be <= 2**CNT_W-1

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  producer has a byte
in_ready  out  1  FIFO can accept; equals !full
in_rs  in  1  register select: 1 = data, 0 = command
in_data  in  8  byte to write
lcd_data  out  8  LCD data bus
lcd_ctrl  out  2  {RS, RW}; RW always 0
lcd_enable  out  1  LCD E strobe
busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE
fifo_count  out  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset is synchronous and active-low on clk: rst_n sampled low at a rising edge. Next-state values:
  - lcd_data=0, lcd_ctrl=0, lcd_enable=0, FIFO empty, fifo_count=0, FSM=IDLE, counter=0.
  - busy=0; in_ready=1 once reset deasserts.
- Reset mid-operation aborts the transfer and drops E at that edge. FIFO contents are discarded.
- Push: in_valid && in_ready at a rising edge stores {in_rs,in_data}; fifo_count increments.
- Push while full is ignored; in_ready is already 0. No bypass: a pop in the same cycle does not free space for that cycle's push.
- Simultaneous push and pop: fifo_count is unchanged; read/write pointers wrap modulo 2**FIFO_AW.
- Pop happens only in IDLE with fifo_count!=0, at the same edge that enters SETUP.
  - A byte pushed into an empty FIFO is popped at the following edge (1-cycle latency).
- FSM, one shared counter reloaded on each state entry:
  - IDLE: E=0; lcd_data/lcd_ctrl keep their last values. Non-empty -> pop, latch lcd_data=byte and lcd_ctrl={rs,0}, go to SETUP.
  - SETUP: E=0 for exactly SETUP_CYCLES cycles -> PULSE.
  - PULSE: E=1 for exactly PULSE_CYCLES cycles -> HOLD.
  - HOLD: E=0, bus unchanged, for HOLD_CYCLES cycles -> WAIT.
  - WAIT: E=0 for DATA_WAIT_CYCLES if rs=1, else CMD_WAIT_CYCLES (or LONG_WAIT_CYCLES, see feature) -> IDLE.
- lcd_data/lcd_ctrl change only on the pop edge, so they are stable across the whole SETUP..WAIT span.
- Total per-byte occupancy from pop edge to IDLE re-entry = SETUP+PULSE+HOLD+WAIT cycles. The next pop occurs 1 cycle after IDLE re-entry.
- All outputs are registered; no combinational path from in_* to lcd_*.
- in_ready and fifo_count reflect registered FIFO state.
- busy = (state!=IDLE) || (fifo_count!=0).

Optional Feature:
- Macro LCD_LONG_CMD_WAIT_EN.
- Defined: a command byte (rs=0) of 8'h01 (clear), 8'h02 or 8'h03 (return home) uses LONG_WAIT_CYCLES in WAIT. All other commands use CMD_WAIT_CYCLES.
- Undefined: every command uses CMD_WAIT_CYCLES; LONG_WAIT_CYCLES is unused.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with in_valid=1 -> lcd_enable=0, lcd_data=0, lcd_ctrl=0, fifo_count=0, busy=0, and nothing accepted. After release: in_ready=1.
- Single data byte: push rs=1, data=8'h41 at cycle 0 (defaults).
  - Pop at cycle 1; lcd_data=8'h41, lcd_ctrl=2'b10 from cycle 2.
  - E high cycles 4-7, low from cycle 8.
  - busy falls and IDLE re-entered 18 cycles after pop.
- FIFO full: push 5 bytes back-to-back while the first is being driven -> in_ready=0 once fifo_count=4, and the 6th push is rejected. All accepted bytes appear on lcd_data in order, each with exactly one 4-cycle E pulse.
- Reset mid-pulse: assert rst_n=0 during PULSE of the second of 3 queued bytes -> E=0 at the next edge, fifo_count=0, and no further pulses after release.
- Command wait: push rs=0, 8'h38 then rs=1, 8'h48 -> the second pop occurs exactly CMD_WAIT_CYCLES+SETUP+PULSE+HOLD+1 = 19 cycles after the first pop.
- Long wait (feature defined): push rs=0, 8'h01 then rs=1, 8'h41 -> gap between pops = 2+4+2+200+1 = 209 cycles. With the macro undefined, the gap is 19 cycles.
